// File: rtl/gc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gc_pkg: shared defaults, width helpers and derived widths for the input hub
// Rev 1.0
// ----------------------------------------------------------------------------
package gc_pkg;

  localparam int DEF_N_ACT     = 4;
  localparam int DEF_DEB_CNT   = 50000;
  localparam int DEF_BD_W      = 12;
  localparam int DEF_NUM_VIEWS = 2;
  localparam int DEF_Q_DEPTH   = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int clog2_min1(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  localparam int CODE_W = clog2_min1(DEF_N_ACT);
  localparam int VIEW_W = clog2_min1(DEF_NUM_VIEWS);
  localparam int CNT_W  = clog2_min1(DEF_DEB_CNT);

endpackage
`default_nettype wire

// File: rtl/gc_btn_cond.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gc_btn_cond: 2-FF synchroniser, debounce counter and press pulse
// Rev 1.0
// ----------------------------------------------------------------------------
module gc_btn_cond
  import gc_pkg::*;
#(
  parameter int DEB_CNT = DEF_DEB_CNT
) (
  input  logic clk,
  input  logic rst_sw,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int            CW      = clog2_min1(DEB_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // The pulse is taken one cycle after the stable level flips, so it is a clean register output.
  always_ff @(posedge clk or posedge rst_sw) begin
    if (rst_sw) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      pulse_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pulse_q      <= stable_q & ~stable_dly_q;
      cnt_q        <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/gc_input_hub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gc_input_hub: button conditioning, action FIFO and board view selection
// Rev 1.0
// ----------------------------------------------------------------------------
module gc_input_hub
  import gc_pkg::*;
#(
  parameter int N_ACT     = DEF_N_ACT,
  parameter int DEB_CNT   = DEF_DEB_CNT,
  parameter int BD_W      = DEF_BD_W,
  parameter int NUM_VIEWS = DEF_NUM_VIEWS,
  parameter int Q_DEPTH   = DEF_Q_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 rst_sw,
  input  logic [N_ACT-1:0]                     act_bt,
  input  logic                                 reset_bt,
  input  logic                                 view_bt,
  input  logic [NUM_VIEWS*BD_W-1:0]            bd_in,
  output logic                                 act_valid,
  output logic [clog2_min1(N_ACT)-1:0]         act_code,
  input  logic                                 act_ready,
  output logic                                 game_reset,
  output logic [BD_W-1:0]                      out,
  output logic [clog2_min1(NUM_VIEWS)-1:0]     view_sel,
  output logic [clog2(Q_DEPTH):0]              q_count,
  output logic                                 drop_led
);

  localparam int CODE_BITS = clog2_min1(N_ACT);
  localparam int VIEW_BITS = clog2_min1(NUM_VIEWS);
  localparam int PTR_W     = clog2_min1(Q_DEPTH);
  localparam int QCNT_W    = clog2(Q_DEPTH) + 1;

  localparam logic [VIEW_BITS-1:0] VIEW_LAST = VIEW_BITS'(NUM_VIEWS - 1);
  localparam logic [QCNT_W-1:0]    Q_FULL    = QCNT_W'(Q_DEPTH);

  logic [N_ACT-1:0] act_pulse;
  logic             rst_pulse;
  logic             view_pulse;

  generate
    for (genvar i = 0; i < N_ACT; i++) begin : g_act_cond
      gc_btn_cond #(.DEB_CNT(DEB_CNT)) u_act (
        .clk     (clk),
        .rst_sw  (rst_sw),
        .btn_i   (act_bt[i]),
        .pulse_o (act_pulse[i])
      );
    end
  endgenerate

  gc_btn_cond #(.DEB_CNT(DEB_CNT)) u_reset (
    .clk     (clk),
    .rst_sw  (rst_sw),
    .btn_i   (reset_bt),
    .pulse_o (rst_pulse)
  );

  gc_btn_cond #(.DEB_CNT(DEB_CNT)) u_view (
    .clk     (clk),
    .rst_sw  (rst_sw),
    .btn_i   (view_bt),
    .pulse_o (view_pulse)
  );

  logic                 sel_valid;
  logic [CODE_BITS-1:0] sel_code;
  logic                 sel_extra;

  // Lowest index wins; any further simultaneous press counts as a lost action.
  always_comb begin
    sel_valid = 1'b0;
    sel_code  = '0;
    sel_extra = 1'b0;
    for (int i = 0; i < N_ACT; i++) begin
      if (act_pulse[i]) begin
        if (!sel_valid) begin
          sel_valid = 1'b1;
          sel_code  = CODE_BITS'(i);
        end else begin
          sel_extra = 1'b1;
        end
      end
    end
  end

  logic [CODE_BITS-1:0] mem_q [Q_DEPTH];
  logic [PTR_W-1:0]     wr_q, wr_d;
  logic [PTR_W-1:0]     rd_q, rd_d;
  logic [QCNT_W-1:0]    count_q, count_d;
  logic                 drop_q, drop_d;
  logic                 pop, push, full, mem_we;

  assign full   = (count_q == Q_FULL);
  assign pop    = (count_q != '0) && act_ready;
  assign push   = sel_valid && (!full || pop);
  assign mem_we = push && !rst_pulse;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (rst_pulse) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      drop_d  = 1'b0;
    end else begin
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      count_d = count_q + QCNT_W'(push) - QCNT_W'(pop);
      if (sel_extra || (sel_valid && !push)) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_sw) begin
    if (rst_sw) begin
      for (int i = 0; i < Q_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_q] <= sel_code;
    end
  end

  logic [VIEW_BITS-1:0] view_sel_q, view_sel_d;
  logic [BD_W-1:0]      out_q, out_d;
  logic                 game_reset_q;

  always_comb begin
    view_sel_d = view_sel_q;
    if (view_pulse) begin
      view_sel_d = (view_sel_q == VIEW_LAST) ? '0 : view_sel_q + VIEW_BITS'(1);
    end
    out_d = '0;
    for (int v = 0; v < NUM_VIEWS; v++) begin
      if (view_sel_q == VIEW_BITS'(v)) out_d = bd_in[v*BD_W +: BD_W];
    end
  end

  always_ff @(posedge clk or posedge rst_sw) begin
    if (rst_sw) begin
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      drop_q       <= 1'b0;
      view_sel_q   <= '0;
      out_q        <= '0;
      game_reset_q <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
      view_sel_q   <= view_sel_d;
      out_q        <= out_d;
      game_reset_q <= 1'b0;
    end
  end

  // The conditioned reset pulse is already a register output and lines up with the flush.
  assign game_reset = rst_pulse;
  assign act_valid  = (count_q != '0);
  assign act_code   = mem_q[rd_q];
  assign q_count    = count_q;
  assign drop_led   = drop_q;
  assign view_sel   = view_sel_q;
  assign out        = out_q;

  logic unused_ok;
  assign unused_ok = game_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_gc_input_hub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gc_input_hub: directed bench for the input hub (DEB_CNT=4, 3 views)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_gc_input_hub;

  logic        clk = 1'b0;
  logic        rst_sw;
  logic [3:0]  act_bt;
  logic        reset_bt;
  logic        view_bt;
  logic [35:0] bd_in;
  logic        act_ready;
  logic        act_valid;
  logic [1:0]  act_code;
  logic        game_reset;
  logic [11:0] out_bd;
  logic [1:0]  view_sel;
  logic [2:0]  q_count;
  logic        drop_led;

  int checks   = 0;
  int failures = 0;

  gc_input_hub #(
    .N_ACT     (4),
    .DEB_CNT   (4),
    .BD_W      (12),
    .NUM_VIEWS (3),
    .Q_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst_sw     (rst_sw),
    .act_bt     (act_bt),
    .reset_bt   (reset_bt),
    .view_bt    (view_bt),
    .bd_in      (bd_in),
    .act_valid  (act_valid),
    .act_code   (act_code),
    .act_ready  (act_ready),
    .game_reset (game_reset),
    .out        (out_bd),
    .view_sel   (view_sel),
    .q_count    (q_count),
    .drop_led   (drop_led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = action mask, 1 = reset button, 2 = view button
  task automatic press(input int which, input logic [3:0] m);
    if (which == 0) act_bt = m;
    else if (which == 1) reset_bt = 1'b1;
    else view_bt = 1'b1;
    repeat (10) tick();
    act_bt = '0; reset_bt = 1'b0; view_bt = 1'b0;
    repeat (10) tick();
  endtask

  task automatic pop_one();
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_sw = 1'b1; act_bt = '0; reset_bt = 1'b0; view_bt = 1'b0;
    act_ready = 1'b0; bd_in = '0;
    repeat (3) tick();
    checks++; if (act_valid !== 1'b0)  begin failures++; $display("FAIL reset_act_valid got=%b exp=0", act_valid); end
    checks++; if (act_code !== 2'd0)   begin failures++; $display("FAIL reset_act_code got=%0d exp=0", act_code); end
    checks++; if (game_reset !== 1'b0) begin failures++; $display("FAIL reset_game_reset got=%b exp=0", game_reset); end
    checks++; if (out_bd !== 12'h000)  begin failures++; $display("FAIL reset_out got=%h exp=000", out_bd); end
    checks++; if (view_sel !== 2'd0)   begin failures++; $display("FAIL reset_view_sel got=%0d exp=0", view_sel); end
    checks++; if (q_count !== 3'd0)    begin failures++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
    checks++; if (drop_led !== 1'b0)   begin failures++; $display("FAIL reset_drop_led got=%b exp=0", drop_led); end
    rst_sw = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_debounce();
    int lat;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      act_bt[2] = 1'b1; tick(); seen |= act_valid; tick(); seen |= act_valid;
      act_bt[2] = 1'b0; tick(); seen |= act_valid; tick(); seen |= act_valid;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL bounce_no_push got=%b exp=0", seen); end
    act_bt[2] = 1'b1;
    lat = 0;
    while (act_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    checks++; if (lat != 8) begin failures++; $display("FAIL debounce_latency got=%0d exp=8", lat); end
    checks++; if (act_code !== 2'd2) begin failures++; $display("FAIL debounce_code got=%0d exp=2", act_code); end
    repeat (5) tick();
    act_bt = '0;
    repeat (10) tick();
    checks++; if (q_count !== 3'd1) begin failures++; $display("FAIL debounce_single_push got=%0d exp=1", q_count); end
    pop_one();
    checks++; if (q_count !== 3'd0 || act_valid !== 1'b0) begin
      failures++; $display("FAIL debounce_pop got=%0d/%b exp=0/0", q_count, act_valid);
    end
  endtask

  task automatic test_order();
    logic [1:0] exp_code [3];
    exp_code[0] = 2'd3; exp_code[1] = 2'd1; exp_code[2] = 2'd0;
    press(0, 4'b1000);
    checks++; if (drop_led !== 1'b0) begin failures++; $display("FAIL order_drop_before got=%b exp=0", drop_led); end
    press(0, 4'b0110);
    checks++; if (drop_led !== 1'b1) begin failures++; $display("FAIL order_drop_after got=%b exp=1", drop_led); end
    press(0, 4'b0001);
    checks++; if (q_count !== 3'd3) begin failures++; $display("FAIL order_q_count got=%0d exp=3", q_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (act_code !== exp_code[i]) begin
        failures++; $display("FAIL order_pop%0d got=%0d exp=%0d", i, act_code, exp_code[i]);
      end
      pop_one();
    end
    checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL order_empty got=%0d exp=0", q_count); end
  endtask

  task automatic test_flush();
    int gr;
    press(0, 4'b0001); press(0, 4'b0010); press(0, 4'b0100);
    checks++; if (q_count !== 3'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", q_count); end
    gr = 0;
    reset_bt = 1'b1;
    for (int i = 0; i < 15; i++) begin tick(); if (game_reset === 1'b1) gr++; end
    reset_bt = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (game_reset === 1'b1) gr++; end
    checks++; if (gr != 1) begin failures++; $display("FAIL flush_pulse_cycles got=%0d exp=1", gr); end
    checks++; if (q_count !== 3'd0 || act_valid !== 1'b0) begin
      failures++; $display("FAIL flush_empty got=%0d/%b exp=0/0", q_count, act_valid);
    end
    checks++; if (drop_led !== 1'b0) begin failures++; $display("FAIL flush_drop got=%b exp=0", drop_led); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) press(0, 4'b0001);
    checks++; if (q_count !== 3'd4) begin failures++; $display("FAIL full_q_count got=%0d exp=4", q_count); end
    checks++; if (drop_led !== 1'b1) begin failures++; $display("FAIL full_drop got=%b exp=1", drop_led); end
    act_bt[1] = 1'b1;
    repeat (7) tick();
    pop_one();
    checks++; if (q_count !== 3'd4) begin failures++; $display("FAIL full_push_pop got=%0d exp=4", q_count); end
    repeat (3) tick();
    act_bt = '0;
    repeat (10) tick();
    for (int i = 0; i < 3; i++) pop_one();
    checks++; if (act_code !== 2'd1 || q_count !== 3'd1) begin
      failures++; $display("FAIL full_tail got=%0d/%0d exp=1/1", act_code, q_count);
    end
    pop_one();
  endtask

  task automatic test_view();
    logic [1:0]  exp_sel [4];
    logic [11:0] exp_out [4];
    logic [11:0] prev;
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd0; exp_sel[3] = 2'd1;
    exp_out[0] = 12'h222; exp_out[1] = 12'h333; exp_out[2] = 12'h111; exp_out[3] = 12'h222;
    bd_in = {12'h333, 12'h222, 12'h111};
    repeat (2) tick();
    checks++; if (out_bd !== 12'h111 || view_sel !== 2'd0) begin
      failures++; $display("FAIL view_init got=%h/%0d exp=111/0", out_bd, view_sel);
    end
    prev = 12'h111;
    for (int k = 0; k < 4; k++) begin
      view_bt = 1'b1;
      repeat (7) tick();
      tick();
      checks++; if (view_sel !== exp_sel[k] || out_bd !== prev) begin
        failures++; $display("FAIL view_sel%0d got=%0d/%h exp=%0d/%h", k, view_sel, out_bd, exp_sel[k], prev);
      end
      tick();
      checks++; if (out_bd !== exp_out[k]) begin
        failures++; $display("FAIL view_out%0d got=%h exp=%h", k, out_bd, exp_out[k]);
      end
      prev = exp_out[k];
      repeat (3) tick();
      view_bt = 1'b0;
      repeat (10) tick();
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    press(1, 4'b0000);
    press(0, 4'b0001);
    press(0, 4'b0010);
    checks++; if (q_count !== 3'd2 || view_sel !== 2'd1) begin
      failures++; $display("FAIL async_pre got=%0d/%0d exp=2/1", q_count, view_sel);
    end
    act_bt[3] = 1'b1;
    repeat (4) tick();
    #2 rst_sw = 1'b1;
    #1;
    checks++; if (q_count !== 3'd0 || act_valid !== 1'b0 || act_code !== 2'd0) begin
      failures++; $display("FAIL async_fifo got=%0d/%b/%0d exp=0/0/0", q_count, act_valid, act_code);
    end
    checks++; if (view_sel !== 2'd0 || out_bd !== 12'h000) begin
      failures++; $display("FAIL async_view got=%0d/%h exp=0/000", view_sel, out_bd);
    end
    checks++; if (drop_led !== 1'b0 || game_reset !== 1'b0) begin
      failures++; $display("FAIL async_misc got=%b/%b exp=0/0", drop_led, game_reset);
    end
    act_bt = '0;
    repeat (2) tick();
    rst_sw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (act_valid === 1'b1 || game_reset === 1'b1 || view_sel !== 2'd0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || q_count !== 3'd0) begin
      failures++; $display("FAIL async_no_spurious got=%b/%0d exp=0/0", seen, q_count);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_order();
    test_flush();
    test_full();
    test_view();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
